// File: rtl/tff_counter_pkg.sv
// Shared definitions for the T-stage event/timer counter: direction encoding
// and the largest modulus a given width can represent.
package tff_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // 64-bit result so that a 32-bit counter's full modulus does not overflow.
  function automatic longint unsigned max_mod(input int width);
    return 64'd1 << width;
  endfunction

endpackage

// File: rtl/tff_counter_if.sv
// Control/status bundle of the counter: master drives the controls,
// slave (the counter) returns count and flags.
interface tff_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_;
  logic             tc;
  logic             wrap;
  logic             done;

  modport master (
    output en, up, load, d,
    input  q, q_, tc, wrap, done
  );

  modport slave (
    input  en, up, load, d,
    output q, q_, tc, wrap, done
  );
endinterface

// File: rtl/tff_stage.sv
// One T-type counter bit: parallel load overrides toggle, q_ is the live
// complement of the stored bit.
module tff_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  input  logic ld,
  input  logic ld_val,
  output logic q,
  output logic q_
);

  // NOTE: clocked state uses non-blocking assignment so every stage samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (ld) begin
      q <= ld_val;
    end else if (t) begin
      q <= ~q;
    end
  end

  assign q_ = ~q;

endmodule

// File: rtl/tff_counter.sv
// Modulo up/down counter built from WIDTH T stages, with parallel load,
// terminal-count, wrap pulse and optional one-shot freeze.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MOD      = max_mod(WIDTH),
  parameter bit              ONE_SHOT = 1'b0
) (
  input logic          clk,
  input logic          rst,
  tff_counter_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("tff_counter: WIDTH must be in 1..32");
  end

  if (MOD < 64'd2 || MOD > max_mod(WIDTH)) begin : g_bad_mod
    $error("tff_counter: MOD must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MOD - 64'd1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] ld;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] t_up;
  logic [WIDTH-1:0] t_dn;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] wrap_val;
  logic             term;
  logic             counting;
  logic             wrap_q;
  logic             done_q;

  assign load_val = (bus.d > MAX_Q) ? MAX_Q : bus.d;
  assign wrap_val = (bus.up == DIR_UP) ? '0 : MAX_Q;
  assign term     = (bus.up == DIR_UP) ? (q == MAX_Q) : (q == '0);
  assign counting = bus.en && !bus.load && !done_q;

  // Bit i toggles when every lower bit is 1 (counting up) or 0 (counting down).
  always_comb begin : p_carry
    logic ones_c;
    logic zeros_c;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    ones_c  = 1'b1;
    zeros_c = 1'b1;
    t_up    = '0;
    t_dn    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t_up[i] = ones_c;
      t_dn[i] = zeros_c;
      ones_c  = ones_c & q[i];
      zeros_c = zeros_c & ~q[i];
    end
  end

  // Load and modulo wrap force the next value; plain counting only toggles.
  always_comb begin
    t      = '0;
    ld     = '0;
    ld_val = '0;
    if (bus.load) begin
      ld     = '1;
      ld_val = load_val;
    end else if (counting && term) begin
      if (!ONE_SHOT) begin
        ld     = '1;
        ld_val = wrap_val;
      end
    end else if (counting) begin
      t = (bus.up == DIR_DOWN) ? t_dn : t_up;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    tff_stage u_stage (
      .clk    (clk),
      .rst    (rst),
      .t      (t[i]),
      .ld     (ld[i]),
      .ld_val (ld_val[i]),
      .q      (q[i]),
      .q_     (q_n[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= counting && term && !ONE_SHOT;
      if (bus.load) begin
        done_q <= 1'b0;
      end else if (counting && term && ONE_SHOT) begin
        done_q <= 1'b1;
      end
    end
  end

  assign bus.q    = q;
  assign bus.q_   = q_n;
  assign bus.tc   = bus.en && !bus.load && term;
  assign bus.wrap = wrap_q;
  assign bus.done = ONE_SHOT ? done_q : 1'b0;

endmodule
